alu_serial_ctrl: RTL and testbench

//  Sequencer for the 1-bit serial ALU: accepts one op command, streams WIDTH operand bits LSB-first.

---
 rtl/alu_serial_ctrl_if.sv | 24 ++
 rtl/alu_serial_ctrl.sv | 128 ++++++++++++
 tb/tb_alu_serial_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_ctrl_if.sv
// Command/response handshake bundle between the core sequencer and the serial ALU controller.
interface alu_serial_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDXW = $clog2(WIDTH);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [IDXW-1:0]  cmd_shamt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;

  modport master (
    output cmd_valid, cmd_op, cmd_shamt, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_shamt, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Sequencer for the 1-bit serial ALU: streams WIDTH operand bits LSB-first for one
// command, applies shifts by index offset, and assembles the serial result.
module alu_serial_ctrl #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDXW  = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  alu_serial_ctrl_if.slave bus,
  output logic [IDXW-1:0] rs1_idx,
  output logic [IDXW-1:0] rs2_idx,
  input  logic            rs1_bit,
  input  logic            rs2_bit,
  output logic            alu_rs1,
  output logic            alu_rs2,
  output logic [2:0]      alu_op,
  output logic            alu_en,
  output logic            alu_start,
  input  logic            alu_result,
  output logic            busy
);

  localparam logic [2:0] OP_SLLI = 3'b101;
  localparam logic [2:0] OP_SRLI = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDXW-1:0]  cnt;
  logic [IDXW-1:0]  shamt;
  logic [WIDTH-1:0] result;
  logic             cap_en;
  logic             accept;
  logic             rs1_ok;
  logic [IDXW-1:0]  rs1_pos;
  logic [IDXW:0]    srli_pos;

  assign accept         = (state == S_IDLE) && bus.cmd_valid;
  assign bus.rsp_result = result;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.cmd_valid) state_nxt = S_PRIME;
      S_PRIME: state_nxt = S_RUN;
      S_RUN:   if (cnt == IDXW'(WIDTH - 1)) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they track the state cycle-exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      busy          <= 1'b0;
      alu_en        <= 1'b0;
      alu_start     <= 1'b0;
      cap_en        <= 1'b0;
    end else begin
      bus.cmd_ready <= (state_nxt == S_IDLE);
      bus.rsp_valid <= (state_nxt == S_DONE);
      busy          <= (state_nxt != S_IDLE);
      alu_en        <= (state_nxt == S_RUN);
      alu_start     <= (state_nxt == S_PRIME);
      cap_en        <= alu_en;
    end
  end

  // Command latch, bit counter and LSB-first result assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op <= '0;
      shamt  <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        alu_op <= bus.cmd_op;
        shamt  <= bus.cmd_shamt;
      end
      if (state == S_PRIME)    cnt <= '0;
      else if (state == S_RUN) cnt <= cnt + IDXW'(1);
      if (cap_en) result <= {alu_result, result[WIDTH-1:1]};
    end
  end

  // Shifts are applied by offsetting the rs1 read index and zero-filling out-of-range bits
  always_comb begin
    srli_pos = {1'b0, cnt} + {1'b0, shamt};
    rs1_pos  = cnt;
    rs1_ok   = 1'b1;
    rs1_idx  = '0;
    rs2_idx  = '0;
    alu_rs1  = 1'b0;
    alu_rs2  = 1'b0;
    if (alu_op == OP_SLLI) begin
      rs1_pos = cnt - shamt;
      rs1_ok  = (cnt >= shamt);
    end else if (alu_op == OP_SRLI) begin
      rs1_pos = srli_pos[IDXW-1:0];
      rs1_ok  = ~srli_pos[IDXW];
    end
    if (state == S_RUN) begin
      rs1_idx = rs1_pos;
      rs2_idx = cnt;
      alu_rs1 = rs1_ok & rs1_bit;
      alu_rs2 = rs2_bit;
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: behavioural serial ALU and register-file bit mux around the
// controller, with a response scoreboard fed at command issue.
module tb_alu_serial_ctrl;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SLLI = 3'b101;
  localparam logic [2:0] OP_SRLI = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rs1_idx, rs2_idx;
  logic       rs1_bit, rs2_bit;
  logic       alu_rs1, alu_rs2;
  logic [2:0] alu_op;
  logic       alu_en, alu_start;
  logic       alu_result;
  logic       busy;
  logic [7:0] rs1_val, rs2_val;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  alu_serial_ctrl_if #(.WIDTH(8)) bus ();

  alu_serial_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .rs1_bit    (rs1_bit),
    .rs2_bit    (rs2_bit),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_op     (alu_op),
    .alu_en     (alu_en),
    .alu_start  (alu_start),
    .alu_result (alu_result),
    .busy       (busy)
  );

  // Register-file bit mux
  assign rs1_bit = rs1_val[rs1_idx];
  assign rs2_bit = rs2_val[rs2_idx];

  // Behavioural 1-bit ALU with registered result and carry
  logic carry;
  logic b_eff, sum_bit, cout;
  assign b_eff   = (alu_op == OP_SUB) ? ~alu_rs2 : alu_rs2;
  assign sum_bit = alu_rs1 ^ b_eff ^ carry;
  assign cout    = (alu_rs1 & b_eff) | (carry & (alu_rs1 ^ b_eff));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      carry      <= 1'b0;
      alu_result <= 1'b0;
    end else begin
      if (alu_start) carry <= (alu_op == OP_SUB);
      if (alu_en) begin
        case (alu_op)
          OP_ADD, OP_SUB: begin alu_result <= sum_bit; carry <= cout; end
          OP_XOR:          alu_result <= alu_rs1 ^ alu_rs2;
          OP_AND:          alu_result <= alu_rs1 & alu_rs2;
          OP_OR:           alu_result <= alu_rs1 | alu_rs2;
          OP_SLLI, OP_SRLI: alu_result <= alu_rs1;
          default:         alu_result <= 1'b0;
        endcase
      end
    end
  end

  // Scoreboard: compare each accepted response against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got %h with empty scoreboard", bus.rsp_result);
      end else begin
        exp_v = exp_q.pop_front();
        if (bus.rsp_result !== exp_v) begin
          errors++;
          $display("FAIL rsp_result got %h expected %h", bus.rsp_result, exp_v);
        end
      end
    end
  end

  // Issue one command at a negedge once the controller is ready; returns at the following negedge
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] sh, input logic [7:0] exp);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_timeout got %b expected 1", bus.cmd_ready);
    end
    rs1_val       = a;
    rs2_val       = b;
    bus.cmd_op    = op;
    bus.cmd_shamt = sh;
    bus.cmd_valid = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Follow an op from its PRIME cycle to DONE, counting cycles since accept
  task automatic wait_done(output int lat, output int n_start, output int start_at, output int n_en);
    lat = 1; n_start = 0; start_at = 0; n_en = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      if (alu_start) begin n_start++; start_at = lat; end
      if (alu_en) n_en++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_valid_timeout got %b expected 1 after %0d cycles", bus.rsp_valid, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, busy, alu_en, alu_start, bus.rsp_valid, alu_rs1, alu_rs2} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 1000000",
               {bus.cmd_ready, busy, alu_en, alu_start, bus.rsp_valid, alu_rs1, alu_rs2});
    end
    checks++;
    if ({alu_op, rs1_idx, rs2_idx, bus.rsp_result} !== 17'h0) begin
      errors++;
      $display("FAIL reset_data got op=%h i1=%h i2=%h res=%h expected all 0",
               alu_op, rs1_idx, rs2_idx, bus.rsp_result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat, ns, sa, ne;
    send(OP_ADD, 8'h5A, 8'h3C, 3'd0, 8'h96);
    wait_done(lat, ns, sa, ne);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL add_latency got %0d expected 11", lat); end
    send(OP_ADD, 8'hFF, 8'h01, 3'd0, 8'h00);
    wait_done(lat, ns, sa, ne);
  endtask

  task automatic test_sub();
    int lat, ns, sa, ne;
    send(OP_SUB, 8'h10, 8'h01, 3'd0, 8'h0F);
    wait_done(lat, ns, sa, ne);
    checks++;
    if (ns !== 1 || sa !== 1) begin
      errors++;
      $display("FAIL sub_alu_start got count=%0d at=%0d expected count=1 at=1", ns, sa);
    end
    checks++;
    if (ne !== 8) begin errors++; $display("FAIL sub_alu_en_cycles got %0d expected 8", ne); end
    send(OP_SUB, 8'h00, 8'h01, 3'd0, 8'hFF);
    wait_done(lat, ns, sa, ne);
    send(OP_SUB, 8'h37, 8'h37, 3'd0, 8'h00);
    wait_done(lat, ns, sa, ne);
  endtask

  task automatic test_logic();
    int lat, ns, sa, ne;
    send(OP_XOR, 8'hA5, 8'h0F, 3'd0, 8'hAA);
    wait_done(lat, ns, sa, ne);
    send(OP_AND, 8'hA5, 8'h0F, 3'd0, 8'h05);
    wait_done(lat, ns, sa, ne);
    send(OP_OR,  8'hA5, 8'h0F, 3'd0, 8'hAF);
    wait_done(lat, ns, sa, ne);
  endtask

  task automatic test_shift();
    int lat, ns, sa, ne;
    send(OP_SLLI, 8'h81, 8'hFF, 3'd1, 8'h02);
    wait_done(lat, ns, sa, ne);
    send(OP_SRLI, 8'h81, 8'hFF, 3'd3, 8'h10);
    wait_done(lat, ns, sa, ne);
    send(OP_SRLI, 8'hF0, 8'h00, 3'd7, 8'h01);
    wait_done(lat, ns, sa, ne);
    send(OP_SLLI, 8'h81, 8'h00, 3'd0, 8'h81);
    wait_done(lat, ns, sa, ne);
    send(OP_SRLI, 8'h81, 8'h00, 3'd0, 8'h81);
    wait_done(lat, ns, sa, ne);
  endtask

  task automatic test_reserved();
    int lat, ns, sa, ne;
    send(OP_RSV, 8'hFF, 8'hFF, 3'd2, 8'h00);
    wait_done(lat, ns, sa, ne);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL rsv_latency got %0d expected 11", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, ns, sa, ne;
    send(OP_XOR, 8'hA5, 8'h0F, 3'd0, 8'hAA);
    wait_done(lat, ns, sa, ne);
    // Second command already pending during the response handshake
    rs1_val       = 8'h10;
    rs2_val       = 8'h20;
    bus.cmd_op    = OP_ADD;
    bus.cmd_shamt = 3'd0;
    bus.cmd_valid = 1'b1;
    exp_q.push_back(8'h30);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got ready=%b busy=%b expected ready=1 busy=0", bus.cmd_ready, busy);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || alu_start !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_prime got busy=%b start=%b ready=%b expected 1 1 0", busy, alu_start, bus.cmd_ready);
    end
    wait_done(lat, ns, sa, ne);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL b2b_latency got %0d expected 11", lat); end
  endtask

  task automatic test_hold();
    int lat, ns, sa, ne;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    send(OP_ADD, 8'h12, 8'h34, 3'd0, 8'h46);
    wait_done(lat, ns, sa, ne);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.rsp_result !== 8'h46) begin
        errors++;
        $display("FAIL hold_cycle%0d got valid=%b ready=%b res=%h expected 1 0 46",
                 i, bus.rsp_valid, bus.cmd_ready, bus.rsp_result);
      end
      bus.cmd_op    = OP_SUB;
      bus.cmd_valid = (i % 2 == 0);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got ready=%b busy=%b valid=%b expected 1 0 0",
               bus.cmd_ready, busy, bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL hold_ignored_cmd got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat, ns, sa, ne;
    send(OP_ADD, 8'hFF, 8'hFF, 3'd0, 8'hFE);
    repeat (4) @(negedge clk);
    checks++;
    if (alu_en !== 1'b1 || rs2_idx !== 3'd3) begin
      errors++;
      $display("FAIL mid_run_pos got en=%b idx=%0d expected en=1 idx=3", alu_en, rs2_idx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.cmd_ready, busy, alu_en, alu_start, bus.rsp_valid, alu_rs1, alu_rs2} !== 7'b1000000) begin
      errors++;
      $display("FAIL mid_reset_ctrl got %b expected 1000000",
               {bus.cmd_ready, busy, alu_en, alu_start, bus.rsp_valid, alu_rs1, alu_rs2});
    end
    checks++;
    if ({alu_op, rs1_idx, rs2_idx, bus.rsp_result} !== 17'h0) begin
      errors++;
      $display("FAIL mid_reset_data got op=%h i1=%h i2=%h res=%h expected all 0",
               alu_op, rs1_idx, rs2_idx, bus.rsp_result);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(OP_ADD, 8'h01, 8'h01, 3'd0, 8'h02);
    wait_done(lat, ns, sa, ne);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_shamt = 3'd0;
    bus.rsp_ready = 1'b1;
    rs1_val       = 8'h00;
    rs2_val       = 8'h00;

    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_reserved();
    test_back_to_back();
    test_hold();
    test_reset_mid();

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
